// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-rate strobe, pixel/line counters and
// registered, mutually aligned sync, data-enable and blanked colour outputs.
module vga_timing #(
    parameter int   COLOR_W  = 4,
    parameter int   CLK_DIV  = 2,
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BP     = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 23,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1,
    parameter int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    parameter int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    parameter int   HW       = $clog2(H_TOTAL),
    parameter int   VW       = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [COLOR_W-1:0] r,
    input  logic [COLOR_W-1:0] g,
    input  logic [COLOR_W-1:0] b,
    output logic [HW-1:0]      ppc,
    output logic [VW-1:0]      plc,
    output logic               pix_en,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               de,
    output logic               line_start,
    output logic               frame_start
);

    localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [3:0]    DIV_ONE  = 4'd1;
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_ONE    = HW'(1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ONE    = VW'(1);

    logic [3:0]         div_q, div_d;
    logic               pix_en_q, pix_en_d;
    logic [HW-1:0]      ppc_q, ppc_d;
    logic [VW-1:0]      plc_q, plc_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic [COLOR_W-1:0] r_q, r_d;
    logic [COLOR_W-1:0] g_q, g_d;
    logic [COLOR_W-1:0] b_q, b_d;
    logic               active;
    logic               in_hs;
    logic               in_vs;

    assign active = (ppc_q < H_ACT) && (plc_q < V_ACT);
    assign in_hs  = (ppc_q >= HS_BEG) && (ppc_q < HS_END);
    assign in_vs  = (plc_q >= VS_BEG) && (plc_q < VS_END);

    always_comb begin
        div_d    = div_q;
        pix_en_d = 1'b0;
        ppc_d    = ppc_q;
        plc_d    = plc_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        de_d     = de_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;
        if (!en) begin
            div_d   = '0;
            ppc_d   = '0;
            plc_d   = '0;
            hsync_d = ~H_POL;
            vsync_d = ~V_POL;
            de_d    = 1'b0;
            r_d     = '0;
            g_d     = '0;
            b_d     = '0;
        end else begin
            pix_en_d = (div_q == 4'd0);
            div_d    = (div_q == DIV_LAST) ? 4'd0 : div_q + DIV_ONE;
            // Outputs sample the current coordinate, so they trail it by one pixel.
            if (pix_en_q) begin
                if (ppc_q == H_LAST) begin
                    ppc_d = '0;
                    plc_d = (plc_q == V_LAST) ? '0 : plc_q + V_ONE;
                end else begin
                    ppc_d = ppc_q + H_ONE;
                end
                hsync_d = in_hs ? H_POL : ~H_POL;
                vsync_d = in_vs ? V_POL : ~V_POL;
                de_d    = active;
                r_d     = active ? r : '0;
                g_d     = active ? g : '0;
                b_d     = active ? b : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            ppc_q    <= '0;
            plc_q    <= '0;
            hsync_q  <= ~H_POL;
            vsync_q  <= ~V_POL;
            de_q     <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            ppc_q    <= ppc_d;
            plc_q    <= plc_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            de_q     <= de_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    assign pix_en      = pix_en_q & en;
    assign line_start  = pix_en & (ppc_q == '0);
    assign frame_start = line_start & (plc_q == '0);
    assign ppc         = ppc_q;
    assign plc         = plc_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;

endmodule
